// File: rtl/fpnew_pkg_snax.sv
// Shared FPU types and format helpers for the SNAX lane unpacker.
// Formats, fp_info_t, classmask_e, widths and lane-count functions.
package fpnew_pkg_snax;

  localparam int unsigned NUM_FP_FORMATS = 5;
  localparam int unsigned FP_FORMAT_BITS = 3;

  typedef enum logic [FP_FORMAT_BITS-1:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  // Ascending range: the leftmost mask bit enables FP32.
  typedef logic [0:NUM_FP_FORMATS-1] fmt_logic_t;

  typedef struct packed {
    logic is_normal;
    logic is_subnormal;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_signalling;
    logic is_quiet;
    logic is_boxed;
  } fp_info_t;

  typedef enum logic [9:0] {
    NEGINF     = 10'b00_0000_0001,
    NEGNORM    = 10'b00_0000_0010,
    NEGSUBNORM = 10'b00_0000_0100,
    NEGZERO    = 10'b00_0000_1000,
    POSZERO    = 10'b00_0001_0000,
    POSSUBNORM = 10'b00_0010_0000,
    POSNORM    = 10'b00_0100_0000,
    POSINF     = 10'b00_1000_0000,
    SNAN       = 10'b01_0000_0000,
    QNAN       = 10'b10_0000_0000
  } classmask_e;

  function automatic int unsigned fp_width(
    input fp_format_e fmt
  );
    case (fmt)
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      FP16ALT: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int unsigned exp_bits(
    input fp_format_e fmt
  );
    case (fmt)
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(
    input fp_format_e fmt
  );
    case (fmt)
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned max_fp_width(
    input fmt_logic_t mask
  );
    int unsigned res;
    res = 0;
    for (int i = 0; i < NUM_FP_FORMATS; i++) begin
      if (mask[i] &&
          fp_width(fp_format_e'(i[2:0])) > res)
        res = fp_width(fp_format_e'(i[2:0]));
    end
    return res;
  endfunction

  function automatic int unsigned min_fp_width(
    input fmt_logic_t mask
  );
    int unsigned res;
    res = 64;
    for (int i = 0; i < NUM_FP_FORMATS; i++) begin
      if (mask[i] &&
          fp_width(fp_format_e'(i[2:0])) < res)
        res = fp_width(fp_format_e'(i[2:0]));
    end
    return res;
  endfunction

  function automatic int unsigned max_num_lanes(
    input int unsigned width,
    input fmt_logic_t  mask,
    input logic        vec
  );
    return vec ? width / min_fp_width(mask) : 1;
  endfunction

  function automatic int unsigned lane_count(
    input int unsigned width,
    input fp_format_e  fmt,
    input logic        vec
  );
    return vec ? width / fp_width(fmt) : 1;
  endfunction

  function automatic logic fmt_supported(
    input fmt_logic_t                mask,
    input logic [FP_FORMAT_BITS-1:0] fmt
  );
    if (int'(fmt) >= NUM_FP_FORMATS) return 1'b0;
    return mask[fmt];
  endfunction

endpackage

// File: rtl/fpnew_snax_lane_classify.sv
// Combinational classifier for one right-aligned lane.
// Ports: lane bits + fmt in; fp_info_t and one-hot classmask_e out.
module fpnew_snax_lane_classify
  import fpnew_pkg_snax::*;
#(
  parameter int unsigned MaxW = 64
) (
  input  logic [MaxW-1:0] lane,
  input  fp_format_e      fmt,
  output fp_info_t        info,
  output classmask_e      cls
);

  logic [63:0] bits;
  logic [63:0] emask;
  logic [63:0] mmask;
  logic [63:0] exp_f;
  logic [63:0] man_f;
  logic        sign;
  logic        qbit;
  logic        e_ones;
  logic        e_zero;
  logic        m_zero;
  int unsigned w;
  int unsigned eb;
  int unsigned mb;

  always_comb begin
    w      = fp_width(fmt);
    eb     = exp_bits(fmt);
    mb     = man_bits(fmt);
    bits   = 64'(lane);
    emask  = (64'd1 << eb) - 64'd1;
    mmask  = (64'd1 << mb) - 64'd1;
    exp_f  = (bits >> mb) & emask;
    man_f  = bits & mmask;
    sign   = bits[w-1];
    qbit   = bits[mb-1];
    e_ones = (exp_f == emask);
    e_zero = (exp_f == 64'd0);
    m_zero = (man_f == 64'd0);
  end

  always_comb begin
    info          = '0;
    info.is_boxed = 1'b1;
    cls           = POSNORM;
    unique case (1'b1)
      e_ones & m_zero: begin
        info.is_inf = 1'b1;
        cls = sign ? NEGINF : POSINF;
      end
      e_ones & ~m_zero: begin
        info.is_nan        = 1'b1;
        info.is_quiet      = qbit;
        info.is_signalling = ~qbit;
        cls = qbit ? QNAN : SNAN;
      end
      e_zero & m_zero: begin
        info.is_zero = 1'b1;
        cls = sign ? NEGZERO : POSZERO;
      end
      e_zero & ~m_zero: begin
        info.is_subnormal = 1'b1;
        cls = sign ? NEGSUBNORM : POSSUBNORM;
      end
      default: begin
        info.is_normal = 1'b1;
        cls = sign ? NEGNORM : POSNORM;
      end
    endcase
  end

endmodule

// File: rtl/fpnew_snax_lane_unpacker.sv
// Streams the lanes of a packed FP vector word out one per beat.
// Ports: valid/ready word in; valid/ready lane beat + info/class out.
module fpnew_snax_lane_unpacker
  import fpnew_pkg_snax::*;
#(
  parameter int unsigned Width         = 64,
  parameter fmt_logic_t  FpFmtMask     = 5'b11111,
  parameter logic        EnableVectors = 1'b1,
  parameter logic        EnableNanBox  = 1'b1,
  localparam int unsigned MaxW =
    max_fp_width(FpFmtMask),
  localparam int unsigned MaxLanes =
    max_num_lanes(Width, FpFmtMask, EnableVectors),
  localparam int unsigned IdxW =
    (MaxLanes > 1) ? $clog2(MaxLanes) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [Width-1:0]           in_data_i,
  input  logic [FP_FORMAT_BITS-1:0]  in_fmt_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [MaxW-1:0]            out_data_o,
  output logic [FP_FORMAT_BITS-1:0]  out_fmt_o,
  output logic [IdxW-1:0]            out_idx_o,
  output logic                       out_last_o,
  output logic [$bits(fp_info_t)-1:0] out_info_o,
  output logic [9:0]                 out_class_o,
  output logic                       err_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]                state_q;
  logic [IdxW-1:0]           idx_q;
  logic [Width-1:0]          word_q;
  logic [FP_FORMAT_BITS-1:0] fmt_q;
  logic                      err_q;

  fp_format_e      fmt_e;
  int unsigned     w;
  int unsigned     nl;
  logic [MaxW-1:0] lmask;
  logic [MaxW-1:0] lane;
  logic            last;
  logic            beat;
  logic            accept;
  logic            supp;
  fp_info_t        info;
  classmask_e      cls;

  assign fmt_e = fp_format_e'(fmt_q);

  // Lane k sits at word[k*w +: w]; bits above w are masked
  // off for the classifier and boxed on the output.
  always_comb begin
    w     = fp_width(fmt_e);
    nl    = lane_count(Width, fmt_e, EnableVectors);
    lmask = (w >= MaxW) ? '1
          : (MaxW'(1) << w) - MaxW'(1);
    lane  = MaxW'(word_q >> (32'(idx_q) * w)) & lmask;
    last  = (32'(idx_q) == nl - 1);
  end

  assign out_valid_o = (state_q == EMIT);
  assign out_last_o  = last;
  assign out_idx_o   = idx_q;
  assign out_fmt_o   = fmt_q;
  assign out_data_o  = EnableNanBox ? (lane | ~lmask)
                                    : lane;
  assign out_info_o  = info;
  assign out_class_o = cls;
  assign err_o       = err_q;

  assign beat       = out_valid_o & out_ready_i;
  assign in_ready_o = (state_q == IDLE) | (beat & last);
  assign accept     = in_valid_i & in_ready_o;
  assign supp       = fmt_supported(FpFmtMask, in_fmt_i);

  fpnew_snax_lane_classify #(
    .MaxW (MaxW)
  ) u_classify (
    .lane (lane),
    .fmt  (fmt_e),
    .info (info),
    .cls  (cls)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      fmt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept & ~supp;
      if (accept & supp) begin
        word_q  <= in_data_i;
        fmt_q   <= in_fmt_i;
        idx_q   <= '0;
        state_q <= EMIT;
      end else if (accept) begin
        state_q <= IDLE;
      end else if (beat & last) begin
        state_q <= IDLE;
      end else if (beat) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpnew_snax_lane_unpacker.sv
// Directed scoreboard bench for the lane unpacker.
// Two instances: all formats enabled, and FP64 disabled.
module tb_fpnew_snax_lane_unpacker;

  localparam logic [9:0] C_NINF  = 10'h001;
  localparam logic [9:0] C_NNORM = 10'h002;
  localparam logic [9:0] C_NSUB  = 10'h004;
  localparam logic [9:0] C_NZERO = 10'h008;
  localparam logic [9:0] C_PZERO = 10'h010;
  localparam logic [9:0] C_PSUB  = 10'h020;
  localparam logic [9:0] C_PNORM = 10'h040;
  localparam logic [9:0] C_PINF  = 10'h080;
  localparam logic [9:0] C_SNAN  = 10'h100;
  localparam logic [9:0] C_QNAN  = 10'h200;

  localparam logic [2:0] F32 = 3'd0;
  localparam logic [2:0] F64 = 3'd1;
  localparam logic [2:0] F16 = 3'd2;
  localparam logic [2:0] F8  = 3'd3;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  fmt;
    logic [2:0]  idx;
    logic        last;
    logic [9:0]  cls;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [2:0]  in_fmt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [2:0]  out_fmt;
  logic [2:0]  out_idx;
  logic        out_last;
  logic [7:0]  out_info;
  logic [9:0]  out_class;
  logic        err;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [63:0] in_data2 = '0;
  logic [2:0]  in_fmt2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [31:0] out_data2;
  logic [2:0]  out_fmt2;
  logic [2:0]  out_idx2;
  logic        out_last2;
  logic [7:0]  out_info2;
  logic [9:0]  out_class2;
  logic        err2;

  fpnew_snax_lane_unpacker #(
    .Width         (64),
    .FpFmtMask     (5'b11111),
    .EnableVectors (1'b1),
    .EnableNanBox  (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_fmt_i    (in_fmt),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_fmt_o   (out_fmt),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last),
    .out_info_o  (out_info),
    .out_class_o (out_class),
    .err_o       (err)
  );

  fpnew_snax_lane_unpacker #(
    .Width         (64),
    .FpFmtMask     (5'b10111),
    .EnableVectors (1'b1),
    .EnableNanBox  (1'b1)
  ) dut2 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid2),
    .in_ready_o  (in_ready2),
    .in_data_i   (in_data2),
    .in_fmt_i    (in_fmt2),
    .out_valid_o (out_valid2),
    .out_ready_i (out_ready2),
    .out_data_o  (out_data2),
    .out_fmt_o   (out_fmt2),
    .out_idx_o   (out_idx2),
    .out_last_o  (out_last2),
    .out_info_o  (out_info2),
    .out_class_o (out_class2),
    .err_o       (err2)
  );

  beat_t exp_q[$];
  int    n_assert = 0;
  int    n_fail = 0;
  int    n_beats = 0;
  int    b0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] v,
                      input int w,
                      input logic [2:0] f,
                      input logic [2:0] i,
                      input logic l,
                      input logic [9:0] c);
    beat_t b;
    b.data = v | (~64'd0 << w);
    b.fmt  = f;
    b.idx  = i;
    b.last = l;
    b.cls  = c;
    exp_q.push_back(b);
  endtask

  task automatic mon();
    beat_t b;
    if (out_valid && out_ready) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(out_idx), 64'hx);
      end else begin
        b = exp_q.pop_front();
        chk("data", out_data, b.data);
        chk("idx", 64'(out_idx), 64'(b.idx));
        chk("last", 64'(out_last), 64'(b.last));
        chk("class", 64'(out_class), 64'(b.cls));
        chk("fmt", 64'(out_fmt), 64'(b.fmt));
        chk("boxed", 64'(out_info[0]), 64'd1);
      end
    end
  endtask

  task automatic cyc(input logic v,
                     input logic [63:0] d,
                     input logic [2:0] f,
                     input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_fmt    = f;
    out_ready = r;
    #1;
    mon();
  endtask

  localparam logic [63:0] WA = 64'h3C00_8001_7C00_0000;
  localparam logic [63:0] WB = 64'hFE00_7D00_0001_BC00;

  task automatic push_a(input int upto);
    if (upto > 0) push(64'h0000, 16, F16, 3'd0, 1'b0, C_PZERO);
    if (upto > 1) push(64'h7C00, 16, F16, 3'd1, 1'b0, C_PINF);
    if (upto > 2) push(64'h8001, 16, F16, 3'd2, 1'b0, C_NSUB);
    if (upto > 3) push(64'h3C00, 16, F16, 3'd3, 1'b1, C_PNORM);
  endtask

  initial begin
    #3;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid2", 64'(out_valid2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // FP32, two lanes
    push(64'h3F800000, 32, F32, 3'd0, 1'b0, C_PNORM);
    push(64'h40490FDB, 32, F32, 3'd1, 1'b1, C_PNORM);
    cyc(1'b1, 64'h40490FDB_3F800000, F32, 1'b1);
    cyc(1'b0, '0, F32, 1'b1);
    cyc(1'b0, '0, F32, 1'b1);
    cyc(1'b0, '0, F32, 1'b1);
    chk("fp32_idle", 64'(out_valid), 64'd0);

    // FP8, eight lanes covering every class but normals/subs of both signs
    push(64'hFC, 8, F8, 3'd0, 1'b0, C_NINF);
    push(64'h83, 8, F8, 3'd1, 1'b0, C_NSUB);
    push(64'h00, 8, F8, 3'd2, 1'b0, C_PZERO);
    push(64'h04, 8, F8, 3'd3, 1'b0, C_PNORM);
    push(64'h80, 8, F8, 3'd4, 1'b0, C_NZERO);
    push(64'h7C, 8, F8, 3'd5, 1'b0, C_PINF);
    push(64'h7E, 8, F8, 3'd6, 1'b0, C_QNAN);
    push(64'h7D, 8, F8, 3'd7, 1'b1, C_SNAN);
    cyc(1'b1, 64'h7D7E_7C80_0400_83FC, F8, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b0, '0, F8, 1'b1);
    chk("fp8_drained", 64'(exp_q.size()), 64'd0);
    chk("fp8_idle", 64'(out_valid), 64'd0);

    // FP16 with a 5-cycle stall on idx2
    push_a(4);
    cyc(1'b1, WA, F16, 1'b1);
    cyc(1'b0, '0, F16, 1'b1);
    cyc(1'b0, '0, F16, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, '0, F16, 1'b0);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_idx", 64'(out_idx), 64'd2);
      chk("stall_data", out_data, 64'hFFFF_FFFF_FFFF_8001);
      chk("stall_class", 64'(out_class), 64'(C_NSUB));
      chk("stall_ready", 64'(in_ready), 64'd0);
    end
    cyc(1'b0, '0, F16, 1'b1);
    cyc(1'b0, '0, F16, 1'b1);
    cyc(1'b0, '0, F16, 1'b1);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Back-to-back FP16 words
    push_a(4);
    push(64'hBC00, 16, F16, 3'd0, 1'b0, C_NNORM);
    push(64'h0001, 16, F16, 3'd1, 1'b0, C_PSUB);
    push(64'h7D00, 16, F16, 3'd2, 1'b0, C_SNAN);
    push(64'hFE00, 16, F16, 3'd3, 1'b1, C_QNAN);
    cyc(1'b1, WA, F16, 1'b1);
    b0 = n_beats;
    cyc(1'b0, '0, F16, 1'b1);
    cyc(1'b0, '0, F16, 1'b1);
    cyc(1'b0, '0, F16, 1'b1);
    cyc(1'b1, WB, F16, 1'b1);
    chk("b2b_ready", 64'(in_ready), 64'd1);
    chk("b2b_idx3", 64'(out_idx), 64'd3);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, F16, 1'b1);
      chk("b2b_valid", 64'(out_valid), 64'd1);
    end
    chk("b2b_beats", 64'(n_beats - b0), 64'd8);
    cyc(1'b0, '0, F16, 1'b1);
    chk("b2b_idle", 64'(out_valid), 64'd0);
    chk("b2b_drained", 64'(exp_q.size()), 64'd0);
    chk("dut_err", 64'(err), 64'd0);

    // Unsupported FP64 on the masked instance
    cyc(1'b0, '0, F16, 1'b1);
    in_valid2 = 1'b1;
    in_fmt2   = F64;
    in_data2  = 64'h3FF0_0000_0000_0000;
    #1;
    chk("u_ready_pre", 64'(in_ready2), 64'd1);
    cyc(1'b0, '0, F16, 1'b1);
    in_valid2 = 1'b0;
    chk("u_err", 64'(err2), 64'd1);
    chk("u_valid", 64'(out_valid2), 64'd0);
    chk("u_ready", 64'(in_ready2), 64'd1);
    cyc(1'b0, '0, F16, 1'b1);
    chk("u_err_pulse", 64'(err2), 64'd0);
    chk("u_valid_b", 64'(out_valid2), 64'd0);
    chk("u_ready_b", 64'(in_ready2), 64'd1);

    // FP32 word, FP64 offered on its final beat
    in_valid2 = 1'b1;
    in_fmt2   = F32;
    in_data2  = 64'hBF80_0000_0000_0000;
    cyc(1'b0, '0, F16, 1'b1);
    in_valid2 = 1'b0;
    chk("u2_valid0", 64'(out_valid2), 64'd1);
    chk("u2_idx0", 64'(out_idx2), 64'd0);
    chk("u2_data0", 64'(out_data2), 64'd0);
    chk("u2_class0", 64'(out_class2), 64'(C_PZERO));
    cyc(1'b0, '0, F16, 1'b1);
    in_valid2 = 1'b1;
    in_fmt2   = F64;
    #1;
    chk("u2_last", 64'(out_last2), 64'd1);
    chk("u2_data1", 64'(out_data2), 64'hBF80_0000);
    chk("u2_class1", 64'(out_class2), 64'(C_NNORM));
    chk("u2_ready", 64'(in_ready2), 64'd1);
    cyc(1'b0, '0, F16, 1'b1);
    in_valid2 = 1'b0;
    chk("u2_idle", 64'(out_valid2), 64'd0);
    chk("u2_err", 64'(err2), 64'd1);
    chk("u2_ready_b", 64'(in_ready2), 64'd1);
    cyc(1'b0, '0, F16, 1'b1);
    chk("u2_err_pulse", 64'(err2), 64'd0);

    // Reset mid-word after the idx1 handshake
    push_a(2);
    cyc(1'b1, WA, F16, 1'b1);
    cyc(1'b0, '0, F16, 1'b1);
    cyc(1'b0, '0, F16, 1'b1);
    @(negedge clk);
    #1;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_idx", 64'(out_idx), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    push(64'h8000_0000_0000_0000, 64, F64, 3'd0, 1'b1, C_NZERO);
    cyc(1'b1, 64'h8000_0000_0000_0000, F64, 1'b1);
    cyc(1'b0, '0, F64, 1'b1);
    cyc(1'b0, '0, F64, 1'b1);
    chk("post_rst_idle", 64'(out_valid), 64'd0);
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
